// File: rtl/core_pkg.sv
// core_pkg: shared CDB packet type and default widths for the result-bus slice
package core_pkg;
    localparam int PHYS_W_DEFAULT = 6;
    localparam int ROB_W_DEFAULT  = 6;
    localparam int XLEN_DEFAULT   = 64;
    localparam int CDB_W_DEFAULT  = 2;

    typedef struct packed {
        logic [PHYS_W_DEFAULT-1:0] tag;
        logic [XLEN_DEFAULT-1:0]   value;
        logic [ROB_W_DEFAULT-1:0]  rob_tag;
    } cdb_pkt_t;
endpackage

// File: rtl/cdb_result_fifo.sv
// cdb_result_fifo: per-FU result buffer; push is refused when full, flush empties it
module cdb_result_fifo
    import core_pkg::*;
#(
    parameter int  DEPTH = 2,
    parameter type pkt_t = cdb_pkt_t
) (
    input  logic clk,
    input  logic reset,
    input  logic flush,
    input  logic push,
    input  pkt_t pkt_in,
    input  logic pop,
    output pkt_t head,
    output logic empty,
    output logic full
);
    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic          wr, rd;
    pkt_t          mem [DEPTH];

    assign wr    = push && !full;
    assign rd    = pop && !empty;
    assign empty = count == '0;
    assign full  = count == (PW+1)'(DEPTH);
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr <= rd ? rd_ptr + 1'b1 : rd_ptr;
            count  <= count + (PW+1)'(wr) - (PW+1)'(rd);
        end
    end

    always_ff @(posedge clk) begin
        if (wr && !flush) mem[wr_ptr] <= pkt_in;
    end
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin grant of up to CDB_W buffered FU results onto registered CDB slots
module cdb_arbiter
    import core_pkg::*;
#(
    parameter int NUM_FU     = 4,
    parameter int CDB_W      = CDB_W_DEFAULT,
    parameter int PHYS_W     = PHYS_W_DEFAULT,
    parameter int ROB_W      = ROB_W_DEFAULT,
    parameter int XLEN       = XLEN_DEFAULT,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic [NUM_FU-1:0]        fu_valid,
    output logic [NUM_FU-1:0]        fu_ready,
    input  logic [NUM_FU*PHYS_W-1:0] fu_tag,
    input  logic [NUM_FU*XLEN-1:0]   fu_value,
    input  logic [NUM_FU*ROB_W-1:0]  fu_rob_tag,
    output logic [CDB_W-1:0]         cdb_valid,
    output logic [CDB_W*PHYS_W-1:0]  cdb_tag,
    output logic [CDB_W*XLEN-1:0]    cdb_value,
    output logic [CDB_W*ROB_W-1:0]   cdb_rob_tag,
    output logic [31:0]              cdb_stall_cnt
);
    localparam int RR_W = NUM_FU > 1 ? $clog2(NUM_FU) : 1;

    typedef struct packed {
        logic [PHYS_W-1:0] tag;
        logic [XLEN-1:0]   value;
        logic [ROB_W-1:0]  rob_tag;
    } pkt_t;

    pkt_t                head [NUM_FU];
    logic [NUM_FU-1:0]   empty, full, grant, gr_rot, rot;
    logic [2*NUM_FU-1:0] ne_dbl, gr_dbl;
    logic [RR_W-1:0]     rr_ptr, rr_next;
    logic [RR_W-1:0]     slot_fu [CDB_W];
    logic [CDB_W-1:0]    slot_ok;
    logic                stall;
    int                  n;

    for (genvar i = 0; i < NUM_FU; i++) begin : g_fu
        cdb_result_fifo #(.DEPTH(FIFO_DEPTH), .pkt_t(pkt_t)) u_fifo (
            .clk   (clk),
            .reset (reset),
            .flush (flush),
            .push  (fu_valid[i]),
            .pkt_in(pkt_t'{tag: fu_tag[i*PHYS_W +: PHYS_W], value: fu_value[i*XLEN +: XLEN],
                           rob_tag: fu_rob_tag[i*ROB_W +: ROB_W]}),
            .pop   (grant[i]),
            .head  (head[i]),
            .empty (empty[i]),
            .full  (full[i])
        );
    end

    assign fu_ready = ~full;
    // Work in rotated space so scan position j is FU (rr_ptr + j) mod NUM_FU
    assign ne_dbl = {~empty, ~empty} >> rr_ptr;
    assign rot    = ne_dbl[NUM_FU-1:0];
    assign gr_dbl = {gr_rot, gr_rot} << rr_ptr;
    assign grant  = gr_dbl[2*NUM_FU-1:NUM_FU];
    assign stall  = |(~empty & ~grant);

    always_comb begin
        gr_rot  = '0;
        slot_ok = '0;
        rr_next = rr_ptr;
        n       = 0;
        for (int k = 0; k < CDB_W; k++) slot_fu[k] = '0;
        for (int j = 0; j < NUM_FU; j++) begin
            if (rot[j] && n < CDB_W) begin
                gr_rot[j] = 1'b1;
                for (int k = 0; k < CDB_W; k++) begin
                    if (n == k) begin
                        slot_ok[k] = 1'b1;
                        slot_fu[k] = RR_W'((int'(rr_ptr) + j) % NUM_FU);
                    end
                end
                rr_next = RR_W'((int'(rr_ptr) + j + 1) % NUM_FU);
                n++;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr        <= '0;
            cdb_valid     <= '0;
            cdb_tag       <= '0;
            cdb_value     <= '0;
            cdb_rob_tag   <= '0;
            cdb_stall_cnt <= '0;
        end else begin
            if (stall && cdb_stall_cnt != '1) cdb_stall_cnt <= cdb_stall_cnt + 1'b1;
            if (flush) begin
                cdb_valid <= '0;
            end else begin
                rr_ptr    <= rr_next;
                cdb_valid <= slot_ok;
                for (int k = 0; k < CDB_W; k++) begin
                    cdb_tag[k*PHYS_W +: PHYS_W]  <= slot_ok[k] ? head[slot_fu[k]].tag : '0;
                    cdb_value[k*XLEN +: XLEN]    <= slot_ok[k] ? head[slot_fu[k]].value : '0;
                    cdb_rob_tag[k*ROB_W +: ROB_W] <= slot_ok[k] ? head[slot_fu[k]].rob_tag : '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed vector table plus reset sequence for cdb_arbiter
module tb_cdb_arbiter;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic [3:0]  fu_valid = '0;
    logic [3:0]  fu_ready;
    logic [23:0] fu_tag = '0;
    logic [255:0] fu_value = '0;
    logic [23:0] fu_rob_tag = '0;
    logic [1:0]  cdb_valid;
    logic [11:0] cdb_tag;
    logic [127:0] cdb_value;
    logic [11:0] cdb_rob_tag;
    logic [31:0] cdb_stall_cnt;

    int n_chk = 0;
    int n_fail = 0;

    cdb_arbiter dut (
        .clk(clk), .reset(reset), .flush(flush),
        .fu_valid(fu_valid), .fu_ready(fu_ready),
        .fu_tag(fu_tag), .fu_value(fu_value), .fu_rob_tag(fu_rob_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .cdb_rob_tag(cdb_rob_tag), .cdb_stall_cnt(cdb_stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] fv;
        logic [5:0] base;
        logic       fl;
        logic [1:0] ev;
        logic [5:0] t0;
        logic [5:0] t1;
        logic [3:0] rdy;
        int         stall;
    } vec_t;

    vec_t vecs [16];

    function automatic logic [63:0] val_of(logic [5:0] t);
        return 64'hDEAD | ({58'h0, t} << 32);
    endfunction

    function automatic logic [5:0] rob_of(logic [5:0] t);
        return t ^ 6'h06;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(logic [3:0] fv, logic [5:0] base, logic fl);
        fu_valid = fv;
        flush = fl;
        for (int i = 0; i < 4; i++) begin
            fu_tag[i*6 +: 6] = base + 6'(i);
            fu_value[i*64 +: 64] = val_of(base + 6'(i));
            fu_rob_tag[i*6 +: 6] = rob_of(base + 6'(i));
        end
    endtask

    task automatic chk_slot(string name, int k, logic [5:0] t);
        chk($sformatf("%s.tag%0d", name, k), 64'(cdb_tag[k*6 +: 6]), 64'(t));
        chk($sformatf("%s.value%0d", name, k), cdb_value[k*64 +: 64], val_of(t));
        chk($sformatf("%s.rob%0d", name, k), 64'(cdb_rob_tag[k*6 +: 6]), 64'(rob_of(t)));
    endtask

    initial begin
        // fv, base, flush | valid, slot0 tag, slot1 tag, ready, stall (-1: skip)
        vecs[0]  = '{4'b0000, 6'd0,  1'b0, 2'b00, 6'd0,  6'd0,  4'b1111, 0};
        vecs[1]  = '{4'b1111, 6'd8,  1'b0, 2'b00, 6'd0,  6'd0,  4'b1111, 0};
        vecs[2]  = '{4'b0000, 6'd0,  1'b0, 2'b11, 6'd8,  6'd9,  4'b1111, 1};
        vecs[3]  = '{4'b0000, 6'd0,  1'b0, 2'b11, 6'd10, 6'd11, 4'b1111, 1};
        vecs[4]  = '{4'b0000, 6'd0,  1'b0, 2'b00, 6'd0,  6'd0,  4'b1111, 1};
        vecs[5]  = '{4'b0001, 6'd5,  1'b0, 2'b00, 6'd0,  6'd0,  4'b1111, 1};
        vecs[6]  = '{4'b0000, 6'd0,  1'b0, 2'b01, 6'd5,  6'd0,  4'b1111, 1};
        vecs[7]  = '{4'b0000, 6'd0,  1'b0, 2'b00, 6'd0,  6'd0,  4'b1111, 1};
        vecs[8]  = '{4'b1111, 6'd16, 1'b0, 2'b00, 6'd0,  6'd0,  4'b1111, 1};
        vecs[9]  = '{4'b1111, 6'd20, 1'b0, 2'b11, 6'd17, 6'd18, 4'b0110, 2};
        vecs[10] = '{4'b1111, 6'd24, 1'b0, 2'b11, 6'd19, 6'd16, 4'b1001, 3};
        vecs[11] = '{4'b1111, 6'd28, 1'b0, 2'b11, 6'd21, 6'd22, 4'b0110, 4};
        vecs[12] = '{4'b0000, 6'd0,  1'b0, 2'b11, 6'd23, 6'd20, 4'b1111, 5};
        vecs[13] = '{4'b1111, 6'd32, 1'b1, 2'b00, 6'd0,  6'd0,  4'b1111, -1};
        vecs[14] = '{4'b0000, 6'd0,  1'b0, 2'b00, 6'd0,  6'd0,  4'b1111, -1};
        vecs[15] = '{4'b0000, 6'd0,  1'b0, 2'b00, 6'd0,  6'd0,  4'b1111, -1};

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        for (int v = 0; v < 16; v++) begin
            drive(vecs[v].fv, vecs[v].base, vecs[v].fl);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d.valid", v), 64'(cdb_valid), 64'(vecs[v].ev));
            chk($sformatf("v%0d.ready", v), 64'(fu_ready), 64'(vecs[v].rdy));
            if (vecs[v].stall >= 0)
                chk($sformatf("v%0d.stall", v), 64'(cdb_stall_cnt), 64'(vecs[v].stall));
            if (vecs[v].ev[0]) chk_slot($sformatf("v%0d", v), 0, vecs[v].t0);
            if (vecs[v].ev[1]) chk_slot($sformatf("v%0d", v), 1, vecs[v].t1);
        end

        // rr_ptr survived the flush (still 1), then reset lands mid-burst
        drive(4'b1111, 6'd48, 1'b0);
        @(posedge clk);
        #1 drive(4'b0000, 6'd0, 1'b0);
        chk("burst.valid0", 64'(cdb_valid), 64'(2'b00));
        @(posedge clk);
        #1;
        chk("burst.valid1", 64'(cdb_valid), 64'(2'b11));
        chk_slot("burst", 0, 6'd49);
        chk_slot("burst", 1, 6'd50);
        #2 reset = 1'b1;
        #1;
        chk("rst.async_valid", 64'(cdb_valid), 64'(2'b00));
        chk("rst.async_stall", 64'(cdb_stall_cnt), 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        chk("rst.ready", 64'(fu_ready), 64'(4'b1111));
        drive(4'b1001, 6'd40, 1'b0);
        @(posedge clk);
        #1 drive(4'b0000, 6'd0, 1'b0);
        chk("post.valid0", 64'(cdb_valid), 64'(2'b00));
        @(posedge clk);
        #1;
        chk("post.valid1", 64'(cdb_valid), 64'(2'b11));
        chk_slot("post", 0, 6'd40);
        chk_slot("post", 1, 6'd43);
        chk("post.stall", 64'(cdb_stall_cnt), 64'd0);
        @(posedge clk);
        #1;
        chk("post.valid2", 64'(cdb_valid), 64'(2'b00));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
